unit_hazard_control: RTL
========================

UNIT_HAZARD_CONTROL -- requirements
Module: unit_hazard_control

Interface
REQ-001 SHALL have parameter BITS_REGS, default 5, register-address width.
REQ-002 SHALL have parameter BITS_STALL_CNT, default 16, width of the load-use stall counter.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 3, number of enabled cycles needed to retire instructions older than HALT.
REQ-004 SHALL have one clock, i_clk (input, 1); all state updates on rising edge.
REQ-005 SHALL have i_reset (input, 1); reset is synchronous and active-high.
REQ-006 SHALL have i_IDEX_mem_read (input, 1), instruction in EX is a load.
REQ-007 SHALL have i_IDEX_rt (input, BITS_REGS), load destination register in EX.
REQ-008 SHALL have i_IFID_rs and i_IFID_rt (input, BITS_REGS each), source registers of the instruction in ID.
REQ-009 SHALL have i_branch_taken (input, 1) and i_jump (input, 1), control transfer resolved in ID.
REQ-010 SHALL have i_halt (input, 1), HALT decoded in ID.
REQ-011 SHALL have i_debug_mode (input, 1), step mode; i_step (input, 1), one-cycle advance pulse.
REQ-012 SHALL have outputs o_pc_write, o_IFID_write, o_IFID_flush, o_IDEX_bubble, o_pipe_enable, o_halted (1 each).
REQ-013 SHALL have outputs o_state (2) and o_stall_count (BITS_STALL_CNT).

Function
REQ-014 SHALL implement FSM states RUN=2'b00, DRAIN=2'b10, HALTED=2'b11; o_state shows the current state; code 2'b01 is unused and SHALL return to RUN.
REQ-015 SHALL define en = !i_debug_mode || i_step; o_pipe_enable = en in RUN/DRAIN, 0 in HALTED.
REQ-016 SHALL define load_use = i_IDEX_mem_read && i_IDEX_rt != 0 && (i_IDEX_rt == i_IFID_rs || i_IDEX_rt == i_IFID_rt).
REQ-017 In RUN with load_use: o_pc_write=0, o_IFID_write=0, o_IDEX_bubble=1, o_IFID_flush=0; exactly one bubble per hazard cycle; no state change.
REQ-018 In RUN, no load_use, (i_branch_taken || i_jump): o_pc_write=1, o_IFID_write=1, o_IFID_flush=1, o_IDEX_bubble=0.
REQ-019 In RUN, no load_use, i_halt: o_pc_write=0, o_IFID_flush=1, o_IDEX_bubble=1; if en, next state DRAIN, drain counter <= DRAIN_CYCLES.
REQ-020 In RUN otherwise: o_pc_write=1, o_IFID_write=1, flush=0, bubble=0.
REQ-021 Priority SHALL be load_use > halt > branch/jump; stalled HALT/branch is re-evaluated next cycle.
REQ-022 In DRAIN: o_pc_write=0, o_IFID_write=0, o_IFID_flush=1, o_IDEX_bubble=1; load_use/branch/halt inputs ignored.
REQ-023 In DRAIN with en: counter==1 -> HALTED, counter<=0; else counter decrements; without en nothing changes.
REQ-024 In HALTED: o_halted=1, o_pc_write=0, o_IFID_write=0, o_IFID_flush=0, o_IDEX_bubble=0; state held until reset.
REQ-025 o_stall_count SHALL increment by 1 on each en cycle in RUN where load_use=1, saturating at all-ones.
REQ-026 All outputs except o_state/o_stall_count are combinational from state and inputs; zero-cycle latency.
REQ-027 When en=0, state, drain counter and o_stall_count SHALL hold.

Reset
REQ-028 On i_reset=1 at a clock edge: state<=RUN, drain counter<=0, o_stall_count<=0, regardless of current state (including mid-DRAIN).
REQ-029 After reset, outputs SHALL be RUN values: o_pc_write=1, o_IFID_write=1, flush=0, bubble=0, o_halted=0, o_pipe_enable=1 when i_debug_mode=0.

Verification
REQ-030 Load-use: mem_read=1, IDEX_rt=5, IFID_rs=5 one cycle -> pc_write=0, IFID_write=0, bubble=1; o_stall_count 0->1.
REQ-031 Zero register: mem_read=1, IDEX_rt=0, IFID_rs=0 -> no stall, stall_count stays 0.
REQ-032 Simultaneous load_use and branch_taken -> stall only, flush=0; next cycle (no hazard) branch -> flush=1.
REQ-033 HALT in RUN, debug_mode=0 -> DRAIN for exactly 3 cycles, then o_state=2'b11, o_halted=1, pipe_enable=0.
REQ-034 Debug step: debug_mode=1, HALT, i_step pulsed every 4th cycle -> HALTED only after 4 step pulses (1 entry + 3 drain).
REQ-035 i_reset=1 during DRAIN (counter=2) -> next cycle o_state=RUN, counter=0, o_stall_count=0.

Source files
------------

// File: rtl/unit_hazard_control.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes, and a HALT
// drain sequence that retires older instructions before freezing the pipe.
module unit_hazard_control #(
    parameter int BITS_REGS      = 5,
    parameter int BITS_STALL_CNT = 16,
    parameter int DRAIN_CYCLES   = 3
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_IDEX_mem_read,
    input  logic [BITS_REGS-1:0]      i_IDEX_rt,
    input  logic [BITS_REGS-1:0]      i_IFID_rs,
    input  logic [BITS_REGS-1:0]      i_IFID_rt,
    input  logic                      i_branch_taken,
    input  logic                      i_jump,
    input  logic                      i_halt,
    input  logic                      i_debug_mode,
    input  logic                      i_step,
    output logic                      o_pc_write,
    output logic                      o_IFID_write,
    output logic                      o_IFID_flush,
    output logic                      o_IDEX_bubble,
    output logic                      o_pipe_enable,
    output logic                      o_halted,
    output logic [1:0]                o_state,
    output logic [BITS_STALL_CNT-1:0] o_stall_count
);

    localparam int CW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_RSVD   = 2'b01,
        ST_DRAIN  = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    state_t        state;
    logic [CW-1:0] drain_cnt;
    logic          en;
    logic          load_use;

    assign en       = !i_debug_mode || i_step;
    assign load_use = i_IDEX_mem_read && (i_IDEX_rt != '0) &&
                      ((i_IDEX_rt == i_IFID_rs) || (i_IDEX_rt == i_IFID_rt));
    assign o_state  = state;

    always_comb begin
        o_pc_write    = 1'b1;
        o_IFID_write  = 1'b1;
        o_IFID_flush  = 1'b0;
        o_IDEX_bubble = 1'b0;
        o_pipe_enable = en;
        o_halted      = 1'b0;
        case (state)
            ST_DRAIN: begin
                o_pc_write    = 1'b0;
                o_IFID_write  = 1'b0;
                o_IFID_flush  = 1'b1;
                o_IDEX_bubble = 1'b1;
            end
            ST_HALTED: begin
                o_pc_write    = 1'b0;
                o_IFID_write  = 1'b0;
                o_pipe_enable = 1'b0;
                o_halted      = 1'b1;
            end
            ST_RUN: begin
                // Load-use wins: a stalled HALT or branch simply re-presents next cycle.
                if (load_use) begin
                    o_pc_write    = 1'b0;
                    o_IFID_write  = 1'b0;
                    o_IDEX_bubble = 1'b1;
                end else if (i_halt) begin
                    o_pc_write    = 1'b0;
                    o_IFID_write  = 1'b0;
                    o_IFID_flush  = 1'b1;
                    o_IDEX_bubble = 1'b1;
                end else if (i_branch_taken || i_jump) begin
                    o_IFID_flush  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= ST_RUN;
            drain_cnt     <= '0;
            o_stall_count <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (en) begin
                        if (load_use) begin
                            if (o_stall_count != '1)
                                o_stall_count <= o_stall_count + 1'b1;
                        end else if (i_halt) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= CW'(DRAIN_CYCLES);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (en) begin
                        // <=1 also guards a zero-length drain from wrapping.
                        if (drain_cnt <= CW'(1)) begin
                            state     <= ST_HALTED;
                            drain_cnt <= '0;
                        end else begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                    end
                end
                ST_HALTED: ;
                default: begin
                    state     <= ST_RUN;
                    drain_cnt <= '0;
                end
            endcase
        end
    end

endmodule
